// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch
// Brief   : PC generation and IF/ID pipeline register. Handles flush, stall
//           and branch redirection, and counts the instructions delivered to ID.
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic [31:0]      new_pc,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_address_i,
    input  logic [31:0]      inst_i,
    output logic [31:0]      pc,
    output logic             ce,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic             r_ce;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_inst;
    logic [CNT_W-1:0] r_fetch_count;

    // Word-aligned views of the two redirect addresses.
    logic [31:0] w_flush_pc;
    logic [31:0] w_branch_pc;

    assign w_flush_pc  = {new_pc[31:2], 2'b00};
    assign w_branch_pc = {branch_target_address_i[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ce          <= 1'b0;
            r_pc          <= RESET_PC;
            r_id_pc       <= 32'h0;
            r_id_inst     <= 32'h0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_RUN;
                    r_ce      <= 1'b1;
                    r_pc      <= RESET_PC;
                    r_id_pc   <= 32'h0;
                    r_id_inst <= 32'h0;
                end
                S_RUN: begin
                    r_ce <= 1'b1;

                    if (flush)
                        r_pc <= w_flush_pc;
                    else if (stall[0])
                        r_pc <= r_pc;
                    else if (branch_flag_i)
                        r_pc <= w_branch_pc;
                    else
                        r_pc <= r_pc + 32'd4;

                    // The delay-slot instruction is captured normally; branches never squash IF/ID.
                    if (flush || (stall[1] && !stall[2])) begin
                        r_id_pc   <= 32'h0;
                        r_id_inst <= 32'h0;
                    end else if (!stall[1]) begin
                        r_id_pc       <= r_pc;
                        r_id_inst     <= inst_i;
                        r_fetch_count <= r_fetch_count + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ce    <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign ce          = r_ce;
    assign id_pc       = r_id_pc;
    assign id_inst     = r_id_inst;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch
// Brief   : Directed self-checking bench for inst_fetch.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i, inst_i2;

    logic [31:0] pc, id_pc, id_inst;
    logic        ce;
    logic [31:0] fetch_count;

    logic [31:0] pc2, id_pc2, id_inst2;
    logic        ce2;
    logic [1:0]  fetch_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign inst_i  = rom(pc);
    assign inst_i2 = rom(pc2);

    inst_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
        .inst_i(inst_i), .pc(pc), .ce(ce), .id_pc(id_pc), .id_inst(id_inst),
        .fetch_count(fetch_count)
    );

    // Narrow counter instance so the modulo wrap is reached in a few captures.
    inst_fetch #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
        .inst_i(inst_i2), .pc(pc2), .ce(ce2), .id_pc(id_pc2), .id_inst(id_inst2),
        .fetch_count(fetch_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                             input logic [31:0] e_idpc, input logic [31:0] e_idinst,
                             input int e_cnt);
        logic [31:0] c32;
        logic [1:0]  c2;
        c32 = 32'(e_cnt);
        c2  = c32[1:0];
        check({tag, ".pc"},       pc,                  e_pc);
        check({tag, ".ce"},       {31'h0, ce},         {31'h0, e_ce});
        check({tag, ".id_pc"},    id_pc,               e_idpc);
        check({tag, ".id_inst"},  id_inst,             e_idinst);
        check({tag, ".count"},    fetch_count,         c32);
        check({tag, ".count_w2"}, {30'h0, fetch_count2}, {30'h0, c2});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;

        // Reset held two cycles, then release.
        tick(); tick();
        check_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 0);
        rst = 1'b0;
        tick();
        check_all("run_first", 32'h0, 1'b1, 32'h0, 32'h0, 0);
        tick();
        check_all("first_cap", 32'h4, 1'b1, 32'h0, rom(32'h0), 1);
        tick();
        check_all("seq", 32'h8, 1'b1, 32'h4, rom(32'h4), 2);

        // Branch with unaligned target; delay slot at 8 still reaches ID.
        branch_flag_i = 1'b1; branch_target_address_i = 32'h00000102;
        tick();
        check_all("branch", 32'h100, 1'b1, 32'h8, rom(32'h8), 3);
        branch_flag_i = 1'b0;
        tick();
        check_all("after_br", 32'h104, 1'b1, 32'h100, rom(32'h100), 4);

        branch_flag_i = 1'b1; branch_target_address_i = 32'h10;
        tick();
        check_all("br_to_10", 32'h10, 1'b1, 32'h104, rom(32'h104), 5);
        branch_flag_i = 1'b0;

        // Full stall freezes everything.
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall_hold", 32'h10, 1'b1, 32'h104, rom(32'h104), 5);
        end
        stall = 6'b000011;
        tick();
        check_all("stall_bubble", 32'h10, 1'b1, 32'h0, 32'h0, 5);
        stall = 6'b0;
        tick();
        check_all("stall_resume", 32'h14, 1'b1, 32'h10, rom(32'h10), 6);

        // Flush wins over stall; low bits of new_pc dropped.
        flush = 1'b1; new_pc = 32'h00000043; stall = 6'b000111;
        tick();
        check_all("flush", 32'h40, 1'b1, 32'h0, 32'h0, 6);
        flush = 1'b0; stall = 6'b0;
        tick();
        check_all("post_flush", 32'h44, 1'b1, 32'h40, rom(32'h40), 7);

        // Branch ignored while the PC is stalled; IF/ID still captures.
        stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        tick();
        check_all("br_stalled", 32'h44, 1'b1, 32'h44, rom(32'h44), 8);
        stall = 6'b0; branch_target_address_i = 32'hFFFFFFFF;
        tick();
        check_all("br_top", 32'hFFFFFFFC, 1'b1, 32'h44, rom(32'h44), 9);
        branch_flag_i = 1'b0;
        tick();
        check_all("pc_wrap", 32'h0, 1'b1, 32'hFFFFFFFC, rom(32'hFFFFFFFC), 10);
        tick();
        check_all("cnt3", 32'h4, 1'b1, 32'h0, rom(32'h0), 11);
        tick();
        check_all("cnt_wrap", 32'h8, 1'b1, 32'h4, rom(32'h4), 12);
        check("cnt_wrap_zero", {30'h0, fetch_count2}, 32'h0);

        // Mid-run reset during branch, flush and stall activity.
        branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        flush = 1'b1; new_pc = 32'h500; stall = 6'b000111; rst = 1'b1;
        tick();
        check_all("mid_reset", 32'h0, 1'b0, 32'h0, 32'h0, 0);
        rst = 1'b0; flush = 1'b0; stall = 6'b0; branch_flag_i = 1'b0;
        tick();
        check_all("re_run", 32'h0, 1'b1, 32'h0, 32'h0, 0);
        tick();
        check_all("re_cap", 32'h4, 1'b1, 32'h0, rom(32'h0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
